uart_tx_fifo: RTL and testbench

//  Buffered 8N1 UART transmitter: the sending end of the serial link that tbuart

---
 rtl/uart_tx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding an LSB-first shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    state_t           state_reg;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_idx_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             ser_tx_reg;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg;
`endif

    logic             empty;
    logic             full;
    logic             push;
    logic             frame_start;
    logic [DIV_W-1:0] eff_div;
    logic [7:0]       head;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LW'(FIFO_DEPTH));
    assign push    = tx_valid & ~full;
    assign head    = mem[rd_ptr_reg];
    assign eff_div = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
    // A new frame may start from IDLE or straight out of the last STOP cycle.
    assign frame_start = enable & ~empty &
                         ((state_reg == S_IDLE) |
                          ((state_reg == S_STOP) & (div_cnt_reg == '0)));

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr_reg] <= tx_data;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (frame_start)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, frame_start})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // The line register follows the state one cycle later, giving the 2-clock push-to-start latency.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg   <= S_IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            div_reg     <= '0;
            div_cnt_reg <= '0;
            ser_tx_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_START:    ser_tx_reg <= 1'b0;
                S_DATA:     ser_tx_reg <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
                S_PARITY:   ser_tx_reg <= parity_reg;
`endif
                default:    ser_tx_reg <= 1'b1;
            endcase

            if (frame_start) begin
                shift_reg   <= head;
                div_reg     <= eff_div;
                div_cnt_reg <= eff_div - DIV_W'(1);
                bit_idx_reg <= '0;
                state_reg   <= S_START;
`ifdef UART_TX_PARITY_EN
                parity_reg  <= ^head;
`endif
            end else if (state_reg != S_IDLE) begin
                if (div_cnt_reg != '0) begin
                    div_cnt_reg <= div_cnt_reg - DIV_W'(1);
                end else begin
                    div_cnt_reg <= div_reg - DIV_W'(1);
                    case (state_reg)
                        S_START: state_reg <= S_DATA;
                        S_DATA: begin
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            if (bit_idx_reg == 3'd7)
`ifdef UART_TX_PARITY_EN
                                state_reg <= S_PARITY;
`else
                                state_reg <= S_STOP;
`endif
                        end
`ifdef UART_TX_PARITY_EN
                        S_PARITY: state_reg <= S_STOP;
`endif
                        default: state_reg <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign tx_ready   = ~full;
    assign ser_tx     = ser_tx_reg;
    assign busy       = (state_reg != S_IDLE) | ~empty;
    assign fifo_level = level_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo: a byte queue plus a bit-accurate
// line receiver that knows each frame's expected bit period.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int DIV_W = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic             clock = 1'b0;
    logic             resetb = 1'b1;
    logic             enable = 1'b0;
    logic [DIV_W-1:0] clk_div = 16'd4;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic             ser_tx;
    logic             busy;
    logic [4:0]       fifo_level;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clock(clock), .resetb(resetb), .enable(enable), .clk_div(clk_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ser_tx(ser_tx), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         tests = 0;
    int         fails = 0;
    int         push_cyc = 0;
    logic [7:0] model_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Drive one push cycle; a byte offered while the model FIFO is full is lost.
    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clock);
        #1 tx_valid = 1'b0;
        push_cyc = cyc;
        if (model_q.size() < DEPTH)
            model_q.push_back(b);
    endtask

    // Wait for a start bit, then check every cycle of the frame against the expected levels.
    task automatic recv(input int div, output int fall_cyc);
        logic [7:0]       exp_b;
        logic [7:0]       got_b;
        logic [NBITS-1:0] frame;
        int               n;
        int               bad;
        fall_cyc = cyc;
        if (model_q.size() == 0) begin
            check_eq("model_underflow", 1, 0);
            return;
        end
        exp_b = model_q.pop_front();
`ifdef UART_TX_PARITY_EN
        frame = {1'b1, ^exp_b, exp_b, 1'b0};
`else
        frame = {1'b1, exp_b, 1'b0};
`endif
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ser_tx !== 1'b0 && n < 3000);
        if (ser_tx !== 1'b0) begin
            check_eq("start_timeout", 1, 0);
            return;
        end
        fall_cyc = cyc;
        bad = 0;
        got_b = '0;
        for (int j = 0; j < NBITS; j++) begin
            for (int k = 0; k < div; k++) begin
                if (j != 0 || k != 0)
                    @(negedge clock);
                if (ser_tx !== frame[j])
                    bad++;
                if (j >= 1 && j <= 8 && k == div / 2)
                    got_b[j-1] = ser_tx;
            end
        end
        check_eq("rx_byte", got_b, exp_b);
        check_eq("bit_shape", bad, 0);
    endtask

    initial begin
        int f1, f2, f3, n, lows, nb;

        #2 resetb = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_ser_tx", ser_tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_level", fifo_level, 0);
        @(negedge clock) resetb = 1'b1;

        // Single frame, start-bit latency and idle afterwards
        enable = 1'b1;
        clk_div = 16'd4;
        @(posedge clock);
        #1 push(8'hA5);
        recv(4, f1);
        check_eq("latency", f1 - push_cyc, 2);
        @(negedge clock);
        check_eq("busy_after", busy, 0);

        // Back-to-back frames without idle gaps
        enable = 1'b0;
        clk_div = 16'd3;
        push(8'h41); push(8'h42); push(8'h43);
        check_eq("level_three", fifo_level, 3);
        enable = 1'b1;
        recv(3, f1); recv(3, f2); recv(3, f3);
        check_eq("gap_1_2", f2 - f1, NBITS * 3);
        check_eq("gap_2_3", f3 - f2, NBITS * 3);
        @(negedge clock);
        check_eq("level_drained", fifo_level, 0);

        // Fill to capacity, overflow dropped, drain in order
        enable = 1'b0;
        clk_div = 16'd2;
        for (int i = 0; i < DEPTH; i++)
            push(8'($urandom));
        check_eq("full_ready", tx_ready, 0);
        check_eq("full_level", fifo_level, DEPTH);
        push(8'hEE);
        check_eq("overflow_level", fifo_level, DEPTH);
        enable = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            recv(2, f1);
        repeat (4) @(negedge clock);
        check_eq("overflow_busy", busy, 0);
        check_eq("overflow_ser", ser_tx, 1);

        // Divider change mid-frame only affects the next frame
        enable = 1'b0;
        clk_div = 16'd4;
        push(8'h5C); push(8'hC3);
        enable = 1'b1;
        fork
            recv(4, f1);
            begin
                repeat (15) @(posedge clock);
                #1 clk_div = 16'd8;
            end
        join
        recv(8, f2);
        check_eq("div_change_gap", f2 - f1, NBITS * 4);

        // Enable dropped mid-frame: frame completes, rest stays queued
        enable = 1'b0;
        clk_div = 16'd3;
        push(8'h3A); push(8'h96);
        enable = 1'b1;
        fork
            recv(3, f1);
            begin
                repeat (6) @(posedge clock);
                #1 enable = 1'b0;
            end
        join
        lows = 0;
        repeat (40) begin
            @(negedge clock);
            if (ser_tx !== 1'b1) lows++;
        end
        check_eq("hold_idle", lows, 0);
        check_eq("hold_level", fifo_level, 1);
        check_eq("hold_busy", busy, 1);
        enable = 1'b1;
        recv(3, f1);

        // Asynchronous reset during the data bits
        enable = 1'b0;
        clk_div = 16'd4;
        push(8'h00); push(8'h11); push(8'h22);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ser_tx !== 1'b0 && n < 100);
        check_eq("reset_test_start", ser_tx, 0);
        repeat (10) @(negedge clock);
        resetb = 1'b0;
        #1;
        check_eq("midrst_ser_tx", ser_tx, 1);
        check_eq("midrst_level", fifo_level, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ready", tx_ready, 1);
        model_q.delete();
        @(negedge clock) resetb = 1'b1;
        lows = 0;
        repeat (80) begin
            @(negedge clock);
            if (ser_tx !== 1'b1) lows++;
        end
        check_eq("no_tail_bits", lows, 0);

        // Minimum bit period and parity-relevant bytes
        clk_div = 16'd0;
        push(8'h07);
        recv(2, f1);
        clk_div = 16'd1;
        push(8'h03);
        recv(2, f1);

        // Random batches with random divider
        for (int r = 0; r < 6; r++) begin
            enable = 1'b0;
            clk_div = 16'($urandom_range(0, 6));
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++)
                push(8'($urandom));
            check_eq("rand_level", fifo_level, nb);
            enable = 1'b1;
            for (int i = 0; i < nb; i++)
                recv(eff(int'(clk_div)), f1);
            @(negedge clock);
            check_eq("rand_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
